// File: rtl/eth_fcs_check.sv
// GMII receive frame checker: strips preamble/SFD, forwards payload through a
// 4-byte delay line so the FCS is never emitted, and reports end-of-frame status.
module eth_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       err_crc,
  output logic       err_len,
  output logic       err_phy
);

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [11:0] MIN_L       = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L       = 12'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        dv_q;
  logic [31:0] crc;
  logic [10:0] len;
  logic [10:0] len_nx;
  logic [7:0]  dly [4];
  logic [2:0]  fill;
  logic        phy_q;
  logic        sof_pend;

  logic        sfd_hit;
  logic        data_byte;
  logic        frame_end;
  logic        emit_ok;
  logic        crc_bad;
  logic        len_bad;

  // Byte enters LSB first, so bit 0 is shifted into the MSB-first register first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sfd_hit   = 1'b0;
    data_byte = 1'b0;
    frame_end = 1'b0;
    if (!gmii_rx_dv) begin
      state_nx  = IDLE;
      frame_end = (state == DATA);
    end else begin
      case (state)
        IDLE:     state_nx = (!dv_q && gmii_rxd == 8'h55) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (gmii_rxd == 8'h55) begin
            state_nx = PREAMBLE;
          end else if (gmii_rxd == 8'hD5) begin
            state_nx = DATA;
            sfd_hit  = 1'b1;
          end else begin
            state_nx = DROP;
          end
        end
        DATA: begin
          state_nx  = DATA;
          data_byte = 1'b1;
        end
        DROP:     state_nx = DROP;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    len_nx  = (len == 11'h7FF) ? len : len + 11'd1;
    emit_ok = ({1'b0, len_nx} <= MAX_L);
    crc_bad = (len < 11'd4) || (crc != CRC_RESIDUE);
    len_bad = ({1'b0, len} < MIN_L) || ({1'b0, len} > MAX_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q       <= 1'b1;
      crc        <= CRC_INIT;
      len        <= '0;
      fill       <= '0;
      phy_q      <= 1'b0;
      sof_pend   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) dly[i] <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_phy    <= 1'b0;
    end else begin
      dv_q       <= gmii_rx_dv;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_crc    <= 1'b0;
      err_len    <= 1'b0;
      err_phy    <= 1'b0;

      if (sfd_hit) begin
        crc      <= CRC_INIT;
        len      <= '0;
        fill     <= '0;
        phy_q    <= 1'b0;
        sof_pend <= 1'b1;
      end

      if (data_byte) begin
        crc    <= crc_byte(crc, gmii_rxd);
        len    <= len_nx;
        dly[0] <= gmii_rxd;
        for (int unsigned i = 1; i < 4; i++) dly[i] <= dly[i-1];
        if (fill != 3'd4) begin
          fill <= fill + 3'd1;
        end else if (emit_ok) begin
          out_valid <= 1'b1;
          out_data  <= dly[3];
          out_sof   <= sof_pend;
          sof_pend  <= 1'b0;
        end
        if (gmii_rx_er) phy_q <= 1'b1;
      end

      // The bytes still held in the delay line are the FCS; dropping fill discards them.
      if (frame_end) begin
        fill       <= '0;
        frame_done <= 1'b1;
        err_crc    <= crc_bad;
        err_len    <= len_bad;
        err_phy    <= phy_q;
        frame_ok   <= !(crc_bad || len_bad || phy_q);
      end
    end
  end

endmodule

// File: tb/tb_eth_fcs_check.sv
// Randomised self-checking bench for eth_fcs_check with a byte-list reference model.
module tb_eth_fcs_check;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sof;
  logic       frame_done;
  logic       frame_ok;
  logic       err_crc;
  logic       err_len;
  logic       err_phy;

  eth_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .err_crc(err_crc), .err_len(err_len), .err_phy(err_phy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] fr[$];
  logic [8:0] exp_b[$];   // {sof, data}
  logic [3:0] exp_s[$];   // {ok, crc, len, phy}

  int         seen     = 0;
  int         done_cnt = 0;
  logic [3:0] last_st  = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected CRC-32 as normally specified for Ethernet, with final inversion.
  function automatic logic [31:0] crc32(input logic [7:0] q[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = crc32(fr, fr.size());
    for (int i = 0; i < 4; i++) fr.push_back(f[8*i +: 8]);
  endtask

  // Expected payload: byte k (1-based) leaves once byte k+4 has arrived within MAX_LEN.
  task automatic model_frame(input bit had_er);
    int n;
    logic [31:0] rx_fcs;
    bit c_bad, l_bad;
    n = fr.size();
    for (int k = 1; k <= n; k++)
      if (k + 4 <= n && k + 4 <= MAX_LEN) exp_b.push_back({(k == 1), fr[k-1]});
    if (n < 4) c_bad = 1'b1;
    else begin
      rx_fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
      c_bad  = (crc32(fr, n - 4) != rx_fcs);
    end
    l_bad = (n < MIN_LEN) || (n > MAX_LEN);
    exp_s.push_back({!(c_bad || l_bad || had_er), c_bad, l_bad, had_er});
  endtask

  task automatic drive(input logic [7:0] b, input logic er);
    @(negedge clk);
    gmii_rx_dv = 1'b1;
    gmii_rxd   = b;
    gmii_rx_er = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  task automatic send(input int pre, input int er_at, input int gap);
    repeat (pre) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < fr.size(); i++) drive(fr[i], (i == er_at));
    idle(gap);
  endtask

  task automatic build_count(input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(8'(i));
  endtask

  // Compare process: every output is checked one step after each rising edge.
  initial begin
    logic [8:0] e;
    logic [3:0] s;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("reset_outputs", {out_valid, out_sof, frame_done, frame_ok, err_crc, err_len, err_phy}, 0);
      end else begin
        if (out_valid) begin
          seen++;
          if (exp_b.size() == 0) chk("unexpected_byte", {out_sof, out_data}, 9'h1FF);
          else begin
            e = exp_b.pop_front();
            chk("payload_byte", {out_sof, out_data}, e);
          end
        end else if (out_sof) begin
          chk("sof_without_valid", out_sof, 0);
        end
        s = {frame_ok, err_crc, err_len, err_phy};
        if (frame_done) begin
          done_cnt++;
          last_st = s;
          if (exp_s.size() == 0) chk("unexpected_frame_done", s, 16);
          else chk("frame_status", s, exp_s.pop_front());
        end else if (s != 4'b0000) begin
          chk("status_without_done", s, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    rst_n = 1'b1;
    idle(3);

    // Model pin: well-known check value of CRC-32("123456789").
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_pin", crc32(fr, 9), 32'hCBF43926);

    // Good 64-byte frame.
    build_count(60); append_fcs();
    seen = 0; model_frame(1'b0); send(7, -1, 1); idle(3);
    chk("good_bytes", seen, 60);
    chk("good_status", last_st, 4'b1000);

    // Short frame "123456789" with its FCS.
    fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    seen = 0; model_frame(1'b0); send(7, -1, 1); idle(3);
    chk("short_bytes", seen, 9);
    chk("short_status", last_st, 4'b0010);

    // Single payload bit flipped.
    build_count(60); append_fcs(); fr[17] = fr[17] ^ 8'h08;
    seen = 0; model_frame(1'b0); send(7, -1, 1); idle(3);
    chk("flip_bytes", seen, 60);
    chk("flip_status", last_st, 4'b0100);

    // Bad preamble byte, then a good frame right after.
    d0 = done_cnt; seen = 0;
    repeat (3) drive(8'h55, 1'b0);
    drive(8'h5D, 1'b0);
    for (int i = 0; i < 40; i++) drive(8'(i), 1'b0);
    idle(4);
    chk("badpre_bytes", seen, 0);
    chk("badpre_done", done_cnt - d0, 0);
    build_count(70); append_fcs();
    model_frame(1'b0); send(3, -1, 1); idle(3);
    chk("after_badpre_status", last_st, 4'b1000);

    // PHY error on one byte.
    build_count(60); append_fcs();
    seen = 0; model_frame(1'b1); send(7, 30, 1); idle(3);
    chk("phy_bytes", seen, 60);
    chk("phy_status", last_st, 4'b0001);

    // Oversize frame.
    fr.delete();
    for (int i = 0; i < 1596; i++) fr.push_back(8'($urandom));
    append_fcs();
    seen = 0; model_frame(1'b0); send(7, -1, 1); idle(3);
    chk("long_bytes", seen, MAX_LEN - 4);
    chk("long_status", last_st, 4'b0010);

    // Reset at byte 20 with dv held high: only bytes already released appear.
    d0 = done_cnt; seen = 0;
    for (int k = 1; k <= 15; k++) exp_b.push_back({(k == 1), 8'(k - 1)});
    repeat (7) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 19; i++) drive(8'(i), 1'b0);
    @(negedge clk); rst_n = 1'b0; gmii_rxd = 8'd19;
    @(negedge clk); gmii_rxd = 8'd20;
    @(negedge clk); rst_n = 1'b1; gmii_rxd = 8'h55;
    repeat (6) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(8'(i), 1'b0);
    idle(4);
    chk("reset_mid_bytes", seen, 15);
    chk("reset_mid_done", done_cnt - d0, 0);
    build_count(64); append_fcs();
    model_frame(1'b0); send(7, -1, 1); idle(3);
    chk("after_reset_status", last_st, 4'b1000);

    // Randomised frames with back-to-back gaps of one idle cycle upward.
    for (int f = 0; f < 16; f++) begin
      int n, er_at;
      bit good;
      n = $urandom_range(1, 100);
      if (f % 3 == 0) n = $urandom_range(64, 100);
      good = ($urandom_range(0, 9) < 7);
      fr.delete();
      if (n >= 4) begin
        for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
        append_fcs();
        if (!good) begin
          int p;
          p = $urandom_range(0, n - 1);
          fr[p] = fr[p] ^ (8'h01 << $urandom_range(0, 7));
        end
      end else begin
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      model_frame(er_at >= 0);
      send($urandom_range(1, 7), er_at, $urandom_range(1, 3));
    end
    idle(6);

    chk("leftover_bytes", exp_b.size(), 0);
    chk("leftover_status", exp_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_fcs_check.md
ETH_FCS_CHECK -- requirements
Module: eth_fcs_check

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum bytes after SFD including FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum bytes after SFD including FCS.
REQ-003 SHALL have port clk  input  1  rising-edge clock, GMII RX byte clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port gmii_rx_dv  input  1  receive data valid.
REQ-006 SHALL have port gmii_rx_er  input  1  receive error from PHY.
REQ-007 SHALL have port gmii_rxd  input  8  receive byte, bit 0 first on wire.
REQ-008 SHALL have port out_valid  output  1  out_data holds one payload byte.
REQ-009 SHALL have port out_data  output  8  payload byte: destination MAC through last byte before FCS.
REQ-010 SHALL have port out_sof  output  1  with out_valid, marks first payload byte of frame.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse, end-of-frame status valid.
REQ-012 SHALL have ports frame_ok, err_crc, err_len, err_phy  output  1 each  status, valid only when frame_done=1, else 0.

Function
REQ-013 SHALL register gmii_rx_dv into dv_q each cycle; dv_q reset value 1.
REQ-014 SHALL use states IDLE, PREAMBLE, DATA, DROP; gmii_rx_dv=0 in any state SHALL force IDLE next cycle.
REQ-015 IDLE: dv=1, dv_q=0, rxd=0x55 -> PREAMBLE; dv=1 otherwise -> DROP.
REQ-016 PREAMBLE: rxd=0x55 -> stay; rxd=0xD5 -> DATA; other byte -> DROP; dv falling in PREAMBLE/DROP SHALL produce no frame_done.
REQ-017 On SFD acceptance, CRC register SHALL load 0xFFFFFFFF, byte counter len SHALL clear, 4-byte delay line SHALL empty, err_phy latch SHALL clear.
REQ-018 DATA: each byte with dv=1 SHALL update CRC with Ethernet CRC-32 (poly 0x04C11DB7, input byte bit-reversed, MSB-first 32-bit register, no output inversion) and increment len, saturating at 2047 (11 bits).
REQ-019 DATA: each byte SHALL shift into 4-byte delay line; when line already held 4 bytes, oldest byte SHALL be emitted: out_valid=1 and out_data=that byte on the cycle after the edge sampling the newer byte (latency 4 byte-times).
REQ-020 out_sof SHALL be 1 with first emitted byte of each frame only.
REQ-021 Once len exceeds MAX_LEN, out_valid SHALL stay 0 for rest of frame.
REQ-022 gmii_rx_er=1 while in DATA SHALL latch err_phy for current frame.
REQ-023 On dv falling in DATA, the 4 bytes in delay line (FCS) SHALL be discarded, never emitted.
REQ-024 frame_done SHALL pulse one cycle after the first cycle with dv=0 following DATA.
REQ-025 err_crc = (CRC register != 0xC704DD7B) after last byte; err_len = (len < MIN_LEN or len > MAX_LEN); frame_ok = !err_crc & !err_len & !err_phy.
REQ-026 len < 4 at end SHALL give err_len=1, err_crc=1, frame_ok=0.
REQ-027 dv falling and rising on consecutive cycles SHALL be handled: new frame detection requires the dv=0 cycle only.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, dv_q=1, CRC=0xFFFFFFFF, len=0, delay line empty, all outputs 0.
REQ-029 Reset mid-frame SHALL abort frame with no frame_done; dv still high after release SHALL go to DROP until dv=0.

Verification
REQ-030 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct 4-byte FCS -> 60 out_valid bytes 0x00..0x3B, out_sof on 0x00, frame_done with frame_ok=1.
REQ-031 Preamble+SFD, bytes 0x31..0x39, then 0x26 0x39 0xF4 0xCB -> 9 bytes emitted, err_crc=0, err_len=1, frame_ok=0.
REQ-032 Scenario REQ-030 with one payload bit flipped -> err_crc=1, frame_ok=0, payload still emitted.
REQ-033 Preamble 0x55 x3 then 0x5D -> DROP, no out_valid, no frame_done until next valid frame, which passes.
REQ-034 gmii_rx_er=1 for one byte mid-frame of REQ-030 -> err_phy=1, frame_ok=0; 1600-byte frame -> err_len=1, out_valid stops after byte 1518.
REQ-035 rst_n pulsed low at byte 20 of a frame, dv held high -> no output until dv=0; next good frame -> frame_ok=1.
